// File: rtl/commit_trace_buffer_pkg.sv
// rtl/commit_trace_buffer_pkg.sv - shared trace entry record and helpers for the commit trace buffer
package commit_trace_buffer_pkg;

  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [31:0]      pc;
    logic [4:0]       reg_idx;
    logic [31:0]      value;
    logic [SEQ_W-1:0] seq;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

  function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
    return (v == '1) ? v : v + SEQ_W'(1);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through storage for trace entries
module trace_fifo
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wr_data,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  // A pop frees a slot on the same edge, so a full FIFO still takes the push.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - captures register writebacks into a sequenced trace FIFO
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            debug_wb_pc,
  input  logic                   debug_wb_ena,
  input  logic [4:0]             debug_wb_reg,
  input  logic [31:0]            debug_wb_value,
  input  logic                   clear,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_pc,
  output logic [4:0]             trace_reg,
  output logic [31:0]            trace_value,
  output logic [15:0]            trace_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  logic             wb_event;
  logic             push;
  logic             pop;
  logic             full;
  logic [SEQ_W-1:0] seq_q;
  trace_entry_t     wr_entry;
  trace_entry_t     head;

  assign wb_event = debug_wb_ena && !(FILTER_X0 && (debug_wb_reg == 5'd0));
  assign push     = wb_event && !clear;
  assign pop      = trace_valid && trace_ready && !clear;

  assign wr_entry = '{pc: debug_wb_pc, reg_idx: debug_wb_reg,
                      value: debug_wb_value, seq: seq_q};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .full    (full)
  );

  assign trace_valid = (count != '0);
  assign trace_pc    = head.pc;
  assign trace_reg   = head.reg_idx;
  assign trace_value = head.value;
  assign trace_seq   = head.seq;

  // Dropped events still consume a sequence number so the consumer sees the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      seq_q    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (wb_event) begin
      seq_q <= seq_q + SEQ_W'(1);
      if (full && !pop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - scoreboard bench for commit_trace_buffer
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;
  logic        clear;
  logic        trace_ready;

  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_value;
  logic [15:0] trace_seq;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic        nf_valid;
  logic [31:0] nf_pc;
  logic [4:0]  nf_reg;
  logic [31:0] nf_value;
  logic [15:0] nf_seq;
  logic [2:0]  nf_count;
  logic        nf_overflow;
  logic [15:0] nf_drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  trace_entry_t sb[$];

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(16), .FILTER_X0(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .debug_wb_pc(debug_wb_pc), .debug_wb_ena(debug_wb_ena),
    .debug_wb_reg(debug_wb_reg), .debug_wb_value(debug_wb_value),
    .clear(clear), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_value(trace_value),
    .trace_seq(trace_seq), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  commit_trace_buffer #(.DEPTH(4), .FILTER_X0(1'b0)) u_dut_nf (
    .clk(clk), .rst_n(rst_n),
    .debug_wb_pc(debug_wb_pc), .debug_wb_ena(debug_wb_ena),
    .debug_wb_reg(debug_wb_reg), .debug_wb_value(debug_wb_value),
    .clear(clear), .trace_valid(nf_valid), .trace_ready(trace_ready),
    .trace_pc(nf_pc), .trace_reg(nf_reg), .trace_value(nf_value),
    .trace_seq(nf_seq), .count(nf_count), .overflow(nf_overflow), .drop_cnt(nf_drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v);
    debug_wb_ena   = 1'b1;
    debug_wb_pc    = pc;
    debug_wb_reg   = r;
    debug_wb_value = v;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [4:0] r,
                              input logic [31:0] v, input logic [15:0] s);
    trace_entry_t e;
    e.pc = pc; e.reg_idx = r; e.value = v; e.seq = s;
    sb.push_back(e);
  endtask

  // Monitor: a handshake seen mid-cycle is the pop that happens at the next edge.
  always @(negedge clk) begin
    if (rst_n && !clear && trace_valid && trace_ready) begin
      trace_entry_t e;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_entry: got pc=%h reg=%0d val=%h seq=%0d with empty scoreboard",
                 trace_pc, trace_reg, trace_value, trace_seq);
      end else begin
        e = sb.pop_front();
        if (trace_pc !== e.pc || trace_reg !== e.reg_idx ||
            trace_value !== e.value || trace_seq !== e.seq) begin
          n_err++;
          $display("FAIL entry: got pc=%h reg=%0d val=%h seq=%0d expected pc=%h reg=%0d val=%h seq=%0d",
                   trace_pc, trace_reg, trace_value, trace_seq,
                   e.pc, e.reg_idx, e.value, e.seq);
        end
      end
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; clear = 1'b0; trace_ready = 1'b0;
    debug_wb_ena = 1'b0; debug_wb_pc = '0; debug_wb_reg = '0; debug_wb_value = '0;
    repeat (3) step();
    chk("reset_valid", {31'd0, trace_valid}, 32'd0);
    chk("reset_count", {27'd0, count}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single event, one-cycle latency, then empty
    trace_ready = 1'b1;
    ev(32'h8000_0000, 5'd5, 32'h1234);
    expect_entry(32'h8000_0000, 5'd5, 32'h1234, 16'd0);
    step();
    debug_wb_ena = 1'b0;
    chk("single_valid", {31'd0, trace_valid}, 32'd1);
    step();
    chk("single_empty", {31'd0, trace_valid}, 32'd0);

    // x0 filtering: dropped by the filtered instance, captured by the other
    ev(32'h8000_0004, 5'd0, 32'hdead);
    step();
    debug_wb_ena = 1'b0;
    chk("x0_filtered_count", {27'd0, count}, 32'd0);
    chk("x0_nf_valid", {31'd0, nf_valid}, 32'd1);
    chk("x0_nf_reg", {27'd0, nf_reg}, 32'd0);
    chk("x0_nf_seq", {16'd0, nf_seq}, 32'd1);
    ev(32'h8000_0008, 5'd6, 32'h55);
    expect_entry(32'h8000_0008, 5'd6, 32'h55, 16'd1);
    step();
    debug_wb_ena = 1'b0;
    step();

    // Overflow: 20 events into 16 slots with no consumer
    clear = 1'b1; step(); clear = 1'b0;
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ev(32'h1000 + 32'(i * 4), 5'(i + 1), 32'(i * 3));
      if (i < 16) expect_entry(32'h1000 + 32'(i * 4), 5'(i + 1), 32'(i * 3), 16'(i));
      step();
    end
    debug_wb_ena = 1'b0;
    chk("ovf_count", {27'd0, count}, 32'd16);
    chk("ovf_overflow", {31'd0, overflow}, 32'd1);
    chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd4);

    // Full FIFO, push and pop on the same edge
    ev(32'h2000, 5'd21, 32'h77);
    expect_entry(32'h2000, 5'd21, 32'h77, 16'd20);
    trace_ready = 1'b1;
    step();
    debug_wb_ena = 1'b0;
    chk("full_pushpop_count", {27'd0, count}, 32'd16);
    chk("full_pushpop_drop", {16'd0, drop_cnt}, 32'd4);
    budget = 40;
    while (count != 0 && budget > 0) begin step(); budget--; end
    chk("drain_count", {27'd0, count}, 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Clear coincident with an event and a pop on a 3-entry FIFO
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev(32'h3000 + 32'(i * 4), 5'(10 + i), 32'h100 + 32'(i));
      expect_entry(32'h3000 + 32'(i * 4), 5'(10 + i), 32'h100 + 32'(i), 16'(21 + i));
      step();
    end
    chk("pre_clear_count", {27'd0, count}, 32'd3);
    clear = 1'b1; trace_ready = 1'b1;
    ev(32'h4000, 5'd13, 32'h999);
    step();
    clear = 1'b0; debug_wb_ena = 1'b0; trace_ready = 1'b0;
    sb.delete();
    chk("clear_count", {27'd0, count}, 32'd0);
    chk("clear_valid", {31'd0, trace_valid}, 32'd0);
    chk("clear_overflow", {31'd0, overflow}, 32'd0);
    chk("clear_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    trace_ready = 1'b1;
    ev(32'h5000, 5'd9, 32'habc);
    expect_entry(32'h5000, 5'd9, 32'habc, 16'd0);
    step();
    debug_wb_ena = 1'b0;
    step();
    chk("post_clear_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset with 8 entries held
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev(32'h6000 + 32'(i * 4), 5'(1 + i), 32'(i));
      step();
    end
    debug_wb_ena = 1'b0;
    chk("pre_reset_count", {27'd0, count}, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, trace_valid}, 32'd0);
    chk("async_reset_count", {27'd0, count}, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    trace_ready = 1'b1;
    ev(32'h7000, 5'd7, 32'h42);
    expect_entry(32'h7000, 5'd7, 32'h42, 16'd0);
    step();
    debug_wb_ena = 1'b0;
    chk("post_reset_valid", {31'd0, trace_valid}, 32'd1);
    step();
    step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
